// File: rtl/cache_lru_partitioned_pkg.sv
// Shared types and default sizing for the partitioned true-LRU engine.
package cache_lru_partitioned_pkg;

  // Threading mode of the core the cache serves.
  typedef enum logic {
    Single_Threaded = 1'b0,
    Multi_Threaded  = 1'b1
  } multithreading_mode_t;

  // Flush sequencer states. The engine leaves reset in FLUSH.
  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } lru_flush_state_t;

  localparam int unsigned LRU_NUM_SET_DEF      = 16;
  localparam int unsigned LRU_WAYS_PER_SET_DEF = 8;
  localparam int unsigned LRU_NUM_THREADS_DEF  = 2;

endpackage

// File: rtl/cache_lru_partitioned_age_update.sv
// cache_lru_age_update: combinational single-touch update of one set's age vector.
// The partition size P is supplied as P-1 (a low-bit mask), so P=WAYS_PER_SET
// makes the whole set one partition. Ways in the touched way's partition that
// are younger than it age by one; the touched way becomes MRU (age 0).
module cache_lru_age_update #(
  parameter int unsigned WAYS_PER_SET   = 8,
  parameter int unsigned WAYS_PER_SET_W = $clog2(WAYS_PER_SET)
) (
  input  logic                                        en_i,
  input  logic [WAYS_PER_SET-1:0][WAYS_PER_SET_W-1:0] ages_i,
  input  logic [WAYS_PER_SET_W-1:0]                   way_i,
  input  logic [WAYS_PER_SET_W-1:0]                   part_size_m1_i,
  output logic [WAYS_PER_SET-1:0][WAYS_PER_SET_W-1:0] ages_o
);

  localparam logic [WAYS_PER_SET_W-1:0] AGE_ONE = WAYS_PER_SET_W'(1);

  logic [WAYS_PER_SET_W-1:0] part_sel_mask;
  logic [WAYS_PER_SET_W-1:0] touched_age;

  // Apply one touch; pass the vector through untouched when disabled.
  always_comb begin
    // NOTE: every combinational output gets a default before any condition,
    // so no path leaves a variable unassigned and no latch is inferred.
    ages_o        = ages_i;
    part_sel_mask = ~part_size_m1_i;
    touched_age   = ages_i[way_i];
    if (en_i) begin
      for (int j = 0; j < WAYS_PER_SET; j++) begin
        if (((WAYS_PER_SET_W'(j) & part_sel_mask) == (way_i & part_sel_mask)) &&
            (ages_i[j] < touched_age)) begin
          ages_o[j] = ages_i[j] + AGE_ONE;
        end
      end
      ages_o[way_i] = '0;
    end
  end

endmodule

// File: rtl/cache_lru_partitioned.sv
// cache_lru_partitioned: true-LRU replacement engine with static per-thread way
// partitioning, two touch ports, registered victim lookup and a flush sequencer
// that rebuilds all ages when the threading mode is (re)latched.
// Optional feature macro: LRU_WAY_LOCK_EN (adds way_lock_mask_i; locked ways are
// never chosen as victim; victim_none_o flags a fully locked partition).
module cache_lru_partitioned
  import cache_lru_partitioned_pkg::*;
#(
  parameter int unsigned NUM_SET        = LRU_NUM_SET_DEF,
  parameter int unsigned WAYS_PER_SET   = LRU_WAYS_PER_SET_DEF,
  parameter int unsigned NUM_THREADS    = LRU_NUM_THREADS_DEF,
  parameter int unsigned NUM_SET_W      = $clog2(NUM_SET),
  parameter int unsigned WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
  parameter int unsigned THR_W          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  multithreading_mode_t      mt_mode_i,
  input  logic                      flush_req_i,
  input  logic                      victim_req_i,
  input  logic [NUM_SET_W-1:0]      victim_set_i,
  input  logic [THR_W-1:0]          victim_thread_i,
  input  logic                      upd0_req_i,
  input  logic [NUM_SET_W-1:0]      upd0_set_i,
  input  logic [WAYS_PER_SET_W-1:0] upd0_way_i,
  input  logic                      upd1_req_i,
  input  logic [NUM_SET_W-1:0]      upd1_set_i,
  input  logic [WAYS_PER_SET_W-1:0] upd1_way_i,
`ifdef LRU_WAY_LOCK_EN
  input  logic [WAYS_PER_SET-1:0]   way_lock_mask_i,
`endif
  output logic                      flush_busy_o,
  output logic                      victim_valid_o,
  output logic [WAYS_PER_SET_W-1:0] victim_way_o,
  output logic                      victim_none_o
);

  typedef logic [WAYS_PER_SET-1:0][WAYS_PER_SET_W-1:0] age_vec_t;

  localparam int unsigned P_MT = WAYS_PER_SET / NUM_THREADS;
  localparam logic [WAYS_PER_SET_W-1:0] P_ST_M1 = WAYS_PER_SET_W'(WAYS_PER_SET - 1);
  localparam logic [WAYS_PER_SET_W-1:0] P_MT_M1 = WAYS_PER_SET_W'(P_MT - 1);
  localparam logic [NUM_SET_W-1:0]      LAST_SET = NUM_SET_W'(NUM_SET - 1);

  // Ages after a rebuild: way w gets w mod P, i.e. w masked by P-1.
  function automatic age_vec_t rebuild_ages(logic [WAYS_PER_SET_W-1:0] p_m1);
    age_vec_t v;
    for (int w = 0; w < WAYS_PER_SET; w++) begin
      v[w] = WAYS_PER_SET_W'(w) & p_m1;
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Flush sequencer state
  // ---------------------------------------------------------------------------
  lru_flush_state_t     state_q, state_d;
  logic [NUM_SET_W-1:0] set_cnt_q, set_cnt_d;
  multithreading_mode_t mode_q, mode_d;
  // Set while the post-reset flush has not yet sampled mt_mode_i.
  logic                 mode_pending_q, mode_pending_d;

  multithreading_mode_t      flush_mode;
  logic [WAYS_PER_SET_W-1:0] flush_part_m1;
  logic [WAYS_PER_SET_W-1:0] part_m1;

  assign flush_mode    = mode_pending_q ? mt_mode_i : mode_q;
  assign flush_part_m1 = (flush_mode == Single_Threaded) ? P_ST_M1 : P_MT_M1;
  assign part_m1       = (mode_q == Single_Threaded) ? P_ST_M1 : P_MT_M1;
  assign flush_busy_o  = (state_q == FLUSH);

  // Next-state logic: walk all sets once in FLUSH, accept flush requests in IDLE.
  always_comb begin
    state_d        = state_q;
    set_cnt_d      = set_cnt_q;
    mode_d         = mode_q;
    mode_pending_d = mode_pending_q;
    case (state_q)
      FLUSH: begin
        if (mode_pending_q) begin
          mode_d         = mt_mode_i;
          mode_pending_d = 1'b0;
        end
        if (set_cnt_q == LAST_SET) begin
          state_d   = IDLE;
          set_cnt_d = '0;
        end else begin
          set_cnt_d = set_cnt_q + NUM_SET_W'(1);
        end
      end
      IDLE: begin
        if (flush_req_i) begin
          state_d   = FLUSH;
          set_cnt_d = '0;
          mode_d    = mt_mode_i;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  // Sequencer registers; reset starts a flush from set 0 in single-threaded mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= FLUSH;
      set_cnt_q      <= '0;
      mode_q         <= Single_Threaded;
      mode_pending_q <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of block evaluation order.
      state_q        <= state_d;
      set_cnt_q      <= set_cnt_d;
      mode_q         <= mode_d;
      mode_pending_q <= mode_pending_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Age storage and touch path
  // ---------------------------------------------------------------------------
  age_vec_t ages_q [NUM_SET];
  age_vec_t ages0, ages1, upd1_src;
  logic     upd0_act, upd1_act;

  assign upd0_act = upd0_req_i && (state_q == IDLE);
  assign upd1_act = upd1_req_i && (state_q == IDLE);
  // Port 1 sees port 0's result when both hit the same set.
  assign upd1_src = (upd0_act && (upd1_set_i == upd0_set_i)) ? ages0 : ages_q[upd1_set_i];

  cache_lru_age_update #(
    .WAYS_PER_SET   (WAYS_PER_SET),
    .WAYS_PER_SET_W (WAYS_PER_SET_W)
  ) u_upd0 (
    .en_i           (upd0_act),
    .ages_i         (ages_q[upd0_set_i]),
    .way_i          (upd0_way_i),
    .part_size_m1_i (part_m1),
    .ages_o         (ages0)
  );

  cache_lru_age_update #(
    .WAYS_PER_SET   (WAYS_PER_SET),
    .WAYS_PER_SET_W (WAYS_PER_SET_W)
  ) u_upd1 (
    .en_i           (upd1_act),
    .ages_i         (upd1_src),
    .way_i          (upd1_way_i),
    .part_size_m1_i (part_m1),
    .ages_o         (ages1)
  );

  // Age array: flush writes one set per cycle; otherwise commit touch results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the age array is built from flops, not a RAM macro, and the
      // reset permutation is observable, so every entry is reset explicitly.
      for (int s = 0; s < NUM_SET; s++) begin
        ages_q[s] <= rebuild_ages(P_ST_M1);
      end
    end else if (state_q == FLUSH) begin
      ages_q[set_cnt_q] <= rebuild_ages(flush_part_m1);
    end else begin
      if (upd0_act) ages_q[upd0_set_i] <= ages0;
      // On a shared set this later write wins and already contains port 0's touch.
      if (upd1_act) ages_q[upd1_set_i] <= ages1;
    end
  end

  // ---------------------------------------------------------------------------
  // Victim search
  // ---------------------------------------------------------------------------
  age_vec_t                  vic_ages;
  logic [WAYS_PER_SET-1:0]   vic_elig;
  logic [WAYS_PER_SET-1:0]   vic_in_part;
  logic [WAYS_PER_SET_W-1:0] vic_base;
  logic [WAYS_PER_SET_W-1:0] vic_best_way;
  logic [WAYS_PER_SET_W-1:0] vic_best_age;
  logic                      vic_found;
  logic                      vic_accept;

  assign vic_accept = victim_req_i && (state_q == IDLE);

`ifdef LRU_WAY_LOCK_EN
  assign vic_elig = ~way_lock_mask_i;
`else
  assign vic_elig = '1;
`endif

  // Oldest eligible way within the requesting thread's partition.
  always_comb begin
    vic_ages     = ages_q[victim_set_i];
    vic_in_part  = '0;
    vic_base     = '0;
    vic_found    = 1'b0;
    vic_best_age = '0;
    if (mode_q != Single_Threaded) begin
      vic_base = WAYS_PER_SET_W'(int'(victim_thread_i) * int'(P_MT));
    end
    vic_best_way = vic_base;
    for (int j = 0; j < WAYS_PER_SET; j++) begin
      vic_in_part[j] = (mode_q == Single_Threaded) ||
                       ((j / int'(P_MT)) == int'(victim_thread_i));
      if (vic_in_part[j] && vic_elig[j] && (!vic_found || (vic_ages[j] > vic_best_age))) begin
        vic_found    = 1'b1;
        vic_best_age = vic_ages[j];
        vic_best_way = WAYS_PER_SET_W'(j);
      end
    end
  end

  // Registered victim response: one-cycle valid pulse per accepted request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else begin
      victim_valid_o <= vic_accept;
      if (vic_accept) victim_way_o <= vic_best_way;
    end
  end

`ifdef LRU_WAY_LOCK_EN
  // No-victim flag travels with the registered way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_none_o <= 1'b0;
    end else if (vic_accept) begin
      victim_none_o <= !vic_found;
    end
  end
`else
  assign victim_none_o = 1'b0;
`endif

  // Changing the threading mode outside a flush request leaves the ages inconsistent.
  mode_stable_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q == IDLE) && !flush_req_i) |-> (mt_mode_i == mode_q))
    else $error("mt_mode changed without flush");

endmodule

// File: tb/tb_cache_lru_partitioned.sv
// Self-checking bench for cache_lru_partitioned: a behavioural LRU model predicts
// victim responses into a scoreboard queue; a negedge monitor pops and compares.
// Build with LRU_WAY_LOCK_EN defined to exercise the lock feature as well.
module tb_cache_lru_partitioned;
  import cache_lru_partitioned_pkg::*;

  localparam int NS = 16;
  localparam int NW = 8;
  localparam int NT = 2;
  localparam int SW = $clog2(NS);
  localparam int WW = $clog2(NW);
  localparam int TW = 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  multithreading_mode_t mt_mode;
  logic                 flush_req, victim_req, upd0_req, upd1_req;
  logic [SW-1:0]        victim_set, upd0_set, upd1_set;
  logic [TW-1:0]        victim_thread;
  logic [WW-1:0]        upd0_way, upd1_way;
  logic [NW-1:0]        lock_mask;
  logic                 flush_busy, victim_valid, victim_none;
  logic [WW-1:0]        victim_way;

  always #5 clk = ~clk;

  cache_lru_partitioned dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .mt_mode_i       (mt_mode),
    .flush_req_i     (flush_req),
    .victim_req_i    (victim_req),
    .victim_set_i    (victim_set),
    .victim_thread_i (victim_thread),
    .upd0_req_i      (upd0_req),
    .upd0_set_i      (upd0_set),
    .upd0_way_i      (upd0_way),
    .upd1_req_i      (upd1_req),
    .upd1_set_i      (upd1_set),
    .upd1_way_i      (upd1_way),
`ifdef LRU_WAY_LOCK_EN
    .way_lock_mask_i (lock_mask),
`endif
    .flush_busy_o    (flush_busy),
    .victim_valid_o  (victim_valid),
    .victim_way_o    (victim_way),
    .victim_none_o   (victim_none)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: ages as plain integers, rules applied directly.
  // ---------------------------------------------------------------------------
  int                   m_age [NS][NW];
  multithreading_mode_t m_mode;
  int                   m_flush_left;
  bit                   m_first;

  typedef struct {
    int way;
    int none;
    int due;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic int psize();
    return (m_mode == Single_Threaded) ? NW : NW / NT;
  endfunction

  function automatic void m_touch(int s, int w);
    int p, base, a;
    p = psize();
    base = (w / p) * p;
    a = m_age[s][w];
    for (int j = base; j < base + p; j++) if (m_age[s][j] < a) m_age[s][j]++;
    m_age[s][w] = 0;
  endfunction

  function automatic void m_victim(int s, int thr, logic [NW-1:0] lk, output int way, output int none);
    int p, lo, best, best_age;
    p = psize();
    lo = (m_mode == Single_Threaded) ? 0 : thr * p;
    best = -1;
    best_age = -1;
    for (int j = lo; j < lo + p; j++) begin
      if (!lk[j] && m_age[s][j] > best_age) begin
        best = j;
        best_age = m_age[s][j];
      end
    end
    if (best < 0) begin way = lo; none = 1; end
    else begin way = best; none = 0; end
  endfunction

  // One clock of stimulus: model consumes the current inputs, then the edge.
  task automatic step();
    exp_t e;
    logic [NW-1:0] lk;
`ifdef LRU_WAY_LOCK_EN
    lk = lock_mask;
`else
    lk = '0;
`endif
    check("flush_busy", {31'b0, flush_busy}, {31'b0, m_flush_left > 0});
    if (m_flush_left > 0) begin
      if (m_first) begin
        m_mode  = mt_mode;
        m_first = 0;
      end
      m_flush_left--;
      if (m_flush_left == 0)
        for (int s = 0; s < NS; s++)
          for (int w = 0; w < NW; w++) m_age[s][w] = w % psize();
    end else begin
      if (victim_req) begin
        m_victim(int'(victim_set), int'(victim_thread), lk, e.way, e.none);
        e.due = cyc + 1;
        exp_q.push_back(e);
      end
      if (upd0_req) m_touch(int'(upd0_set), int'(upd0_way));
      if (upd1_req) m_touch(int'(upd1_set), int'(upd1_way));
      if (flush_req) begin
        m_mode = mt_mode;
        m_flush_left = NS;
      end
    end
    @(posedge clk);
    #1;
    victim_req = 1'b0;
    upd0_req   = 1'b0;
    upd1_req   = 1'b0;
    flush_req  = 1'b0;
  endtask

  task automatic vic(int s, int thr);
    victim_req    = 1'b1;
    victim_set    = SW'(s);
    victim_thread = TW'(thr);
    step();
  endtask

  task automatic touch(int s, int w);
    upd0_req = 1'b1;
    upd0_set = SW'(s);
    upd0_way = WW'(w);
    step();
  endtask

  task automatic run_flush();
    for (int i = 0; i < NS + 4 && m_flush_left > 0; i++) step();
  endtask

  // Asserts reset asynchronously, checks reset outputs, releases after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_flush_busy", {31'b0, flush_busy}, 32'd1);
    check("rst_victim_valid", {31'b0, victim_valid}, 32'd0);
    check("rst_victim_way", {29'b0, victim_way}, 32'd0);
    check("rst_victim_none", {31'b0, victim_none}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_mode = Single_Threaded;
    m_flush_left = NS;
    m_first = 1;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) m_age[s][w] = w;
  endtask

  // Monitor: compare each presented victim against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (victim_valid) begin
        if (exp_q.size() == 0) begin
          check("victim_valid_unexpected", {31'b0, victim_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("victim_latency", cyc, mon_e.due);
          check("victim_way", {29'b0, victim_way}, mon_e.way);
          check("victim_none", {31'b0, victim_none}, mon_e.none);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        mon_e = exp_q.pop_front();
        check("victim_valid_missing", {31'b0, victim_valid}, 32'd1);
      end
    end
  end

  task automatic random_phase(int n);
    for (int i = 0; i < n; i++) begin
      victim_req    = ($urandom_range(0, 1) == 1);
      victim_set    = SW'($urandom_range(0, 3));
      victim_thread = TW'($urandom_range(0, NT - 1));
      upd0_req      = ($urandom_range(0, 2) != 0);
      upd0_set      = SW'($urandom_range(0, 3));
      upd0_way      = WW'($urandom_range(0, NW - 1));
      upd1_req      = ($urandom_range(0, 2) != 0);
      upd1_set      = SW'($urandom_range(0, 3));
      upd1_way      = WW'($urandom_range(0, NW - 1));
`ifdef LRU_WAY_LOCK_EN
      lock_mask     = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '0;
`endif
      step();
    end
    lock_mask = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mt_mode = Single_Threaded;
    flush_req = 0; victim_req = 0; upd0_req = 0; upd1_req = 0;
    victim_set = '0; victim_thread = '0; upd0_set = '0; upd0_way = '0;
    upd1_set = '0; upd1_way = '0; lock_mask = '0;
    do_reset();

    // Post-reset flush with ignored victim, flush and touch requests.
    for (int i = 0; i < NS; i++) begin
      if (i == 3) begin victim_req = 1; victim_set = 3; end
      if (i == 5) flush_req = 1;
      if (i == 7) begin upd0_req = 1; upd0_set = 3; upd0_way = 2; end
      step();
    end

    // Single-threaded LRU walk on set 3.
    vic(3, 0);
    touch(3, 7);
    vic(3, 0);
    for (int w = 6; w >= 0; w--) touch(3, w);
    vic(3, 0);

    // Dual-port same set, different ways; then same way collision.
    upd0_req = 1; upd0_set = 2; upd0_way = 1;
    upd1_req = 1; upd1_set = 2; upd1_way = 2;
    step();
    vic(2, 0);
    touch(2, 7);
    vic(2, 0);
    upd0_req = 1; upd0_set = 4; upd0_way = 5;
    upd1_req = 1; upd1_set = 4; upd1_way = 5;
    step();
    vic(4, 0);

    // Victim uses pre-touch ages when touched in the same cycle.
    victim_req = 1; victim_set = 5; upd0_req = 1; upd0_set = 5; upd0_way = 7;
    step();
    vic(5, 0);

`ifdef LRU_WAY_LOCK_EN
    lock_mask = 8'h80;
    vic(6, 0);
    lock_mask = 8'hFF;
    vic(6, 0);
    touch(6, 3);
    lock_mask = '0;
    vic(6, 0);
`endif

    // Switch to two-thread partitioning.
    mt_mode = Multi_Threaded; flush_req = 1;
    step();
    run_flush();
    vic(0, 1);
    touch(0, 7);
    vic(0, 1);
    vic(0, 0);
    random_phase(400);

    // Reset in the middle of a flush restarts it from set 0.
    flush_req = 1;
    step();
    for (int i = 0; i < 5; i++) step();
    do_reset();
    run_flush();
    vic(1, 1);

    // Back to single-threaded for a final random run.
    mt_mode = Single_Threaded; flush_req = 1;
    step();
    run_flush();
    random_phase(300);

    for (int i = 0; i < 3; i++) step();
    check("pending_responses", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
